// File: rtl/user_wb_arb_pkg.sv
// ============================================================================
// Module      : user_wb_arb_pkg
// Description : Shared types and constants for the two-master Wishbone
//               arbiter (state encoding, owner encoding, grant constants).
// Config      : USER_WB_ARB_TIMEOUT_EN (used by user_wb_arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package user_wb_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Owner encoding: a single bit selects which master owns the slave
    typedef logic owner_t;
    localparam owner_t OWN_M0 = 1'b0;
    localparam owner_t OWN_M1 = 1'b1;

    localparam logic [1:0]  GRANT_NONE          = 2'b00;
    localparam logic [31:0] TIMEOUT_DAT_DEFAULT = 32'hDEADBEEF;

    // One-hot grant vector for a given owner
    function automatic logic [1:0] owner_onehot(input owner_t own);
        return (own == OWN_M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/user_wb_rr_pick.sv
// ============================================================================
// Module      : user_wb_rr_pick
// Description : Combinational two-request round-robin picker. On a tie the
//               master that did not own the bus last wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_wb_rr_pick
    import user_wb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output logic       valid_o,
    output owner_t     pick_o
);

    // Pick a single requester, alternating on a tie
    always_comb begin
        valid_o = |req_i;
        pick_o  = OWN_M0;
        if (&req_i) begin
            pick_o = (last_i == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (req_i[1]) begin
            pick_o = OWN_M1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/user_wb_arbiter.sv
// ============================================================================
// Module      : user_wb_arbiter
// Description : Two-master, one-slave Wishbone arbiter. Round-robin grant,
//               ownership held for exactly one transaction, one dead cycle
//               between transactions. Slave request and master responses are
//               combinational muxes driven by the owner register.
// Config      : USER_WB_ARB_TIMEOUT_EN - when defined, a watchdog terminates
//               a BUSY cycle after TIMEOUT_CYC cycles without s_ack_i and
//               returns TIMEOUT_DAT to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module user_wb_arbiter
    import user_wb_arb_pkg::*;
#(
    parameter int             AW          = 32,
    parameter int             DW          = 32,
    parameter int             TIMEOUT_CYC = 255,
    parameter logic [DW-1:0]  TIMEOUT_DAT = DW'(TIMEOUT_DAT_DEFAULT)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // Master 0 (management SoC)
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic              m0_ack_o,
    output logic [DW-1:0]     m0_dat_o,
    // Master 1 (logic-analyzer driven)
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic              m1_ack_o,
    output logic [DW-1:0]     m1_dat_o,
    // Slave
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    input  logic              s_ack_i,
    input  logic [DW-1:0]     s_dat_i,
    // Status
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam int SW = DW / 8;

    arb_state_e        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;

    logic [1:0]        req;
    logic              pick_valid;
    owner_t            pick;

    logic              busy;
    logic              own_cyc;
    logic              own_stb;
    logic              own_we;
    logic [SW-1:0]     own_sel;
    logic [AW-1:0]     own_adr;
    logic [DW-1:0]     own_dat;
    logic              timeout_hit;
    logic              rsp_ack;
    logic [DW-1:0]     rsp_dat;

    assign req  = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
    assign busy = (state_q == ARB_BUSY);

    user_wb_rr_pick u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .pick_o  (pick)
    );

    // Select the current owner's request signals
    always_comb begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        own_we  = m0_we_i;
        own_sel = m0_sel_i;
        own_adr = m0_adr_i;
        own_dat = m0_dat_i;
        if (owner_q == OWN_M1) begin
            own_cyc = m1_cyc_i;
            own_stb = m1_stb_i;
            own_we  = m1_we_i;
            own_sel = m1_sel_i;
            own_adr = m1_adr_i;
            own_dat = m1_dat_i;
        end
    end

`ifdef USER_WB_ARB_TIMEOUT_EN
    // Counter holds the BUSY cycle index (0 on the first BUSY cycle)
    localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count BUSY cycles; held at zero while idle so each BUSY starts fresh
    always_comb begin
        cnt_d = '0;
        if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A slave ack in the final cycle takes precedence over the timeout
    assign timeout_hit = busy & own_cyc & ~s_ack_i &
                         (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_cfg;
    assign unused_cfg  = (TIMEOUT_CYC == 0);
    assign timeout_hit = 1'b0;
`endif

    // FSM, owner and round-robin history registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_M0;
            last_q  <= OWN_M1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant from IDLE, release on ack, abort or timeout.
    // An aborted transaction also counts as a turn so a waiting master
    // is served next.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!own_cyc || s_ack_i || timeout_hit) begin
                    last_d  = owner_q;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output muxing: slave sees the owner, only the owner sees responses
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        grant_o   = GRANT_NONE;
        m0_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_dat_o  = '0;
        rsp_ack   = 1'b0;
        rsp_dat   = '0;
        timeout_o = timeout_hit;
        if (busy) begin
            s_cyc_o = own_cyc & ~timeout_hit;
            s_stb_o = own_stb & ~timeout_hit;
            s_we_o  = own_we;
            s_sel_o = own_sel;
            s_adr_o = own_adr;
            s_dat_o = own_dat;
            grant_o = owner_onehot(owner_q);
            rsp_ack = own_cyc & (s_ack_i | timeout_hit);
            rsp_dat = timeout_hit ? TIMEOUT_DAT : s_dat_i;
            if (owner_q == OWN_M1) begin
                m1_ack_o = rsp_ack;
                m1_dat_o = rsp_dat;
            end else begin
                m0_ack_o = rsp_ack;
                m0_dat_o = rsp_dat;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_user_wb_arbiter.sv
// ============================================================================
// Module      : tb_user_wb_arbiter
// Description : Self-checking bench for user_wb_arbiter: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Config      : USER_WB_ARB_TIMEOUT_EN selects the watchdog expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_user_wb_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 16;
`ifdef USER_WB_ARB_TIMEOUT_EN
    localparam bit TO_EN  = 1'b1;
`else
    localparam bit TO_EN  = 1'b0;
`endif
    localparam logic [DW-1:0] TO_DAT = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        m_cyc, m_stb, m_we;
    logic [SW-1:0]     m_sel [2];
    logic [AW-1:0]     m_adr [2];
    logic [DW-1:0]     m_dat [2];
    logic              m0_ack, m1_ack;
    logic [DW-1:0]     m0_rdat, m1_rdat;
    logic              s_cyc, s_stb, s_we;
    logic [SW-1:0]     s_sel;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_wdat;
    logic              s_ack;
    logic [DW-1:0]     s_rdat;
    logic [1:0]        grant;
    logic              tout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    user_wb_arbiter #(
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT_CYC (TO_CYC),
        .TIMEOUT_DAT (TO_DAT)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .m0_cyc_i  (m_cyc[0]),
        .m0_stb_i  (m_stb[0]),
        .m0_we_i   (m_we[0]),
        .m0_sel_i  (m_sel[0]),
        .m0_adr_i  (m_adr[0]),
        .m0_dat_i  (m_dat[0]),
        .m0_ack_o  (m0_ack),
        .m0_dat_o  (m0_rdat),
        .m1_cyc_i  (m_cyc[1]),
        .m1_stb_i  (m_stb[1]),
        .m1_we_i   (m_we[1]),
        .m1_sel_i  (m_sel[1]),
        .m1_adr_i  (m_adr[1]),
        .m1_dat_i  (m_dat[1]),
        .m1_ack_o  (m1_ack),
        .m1_dat_o  (m1_rdat),
        .s_cyc_o   (s_cyc),
        .s_stb_o   (s_stb),
        .s_we_o    (s_we),
        .s_sel_o   (s_sel),
        .s_adr_o   (s_adr),
        .s_dat_o   (s_wdat),
        .s_ack_i   (s_ack),
        .s_dat_i   (s_rdat),
        .grant_o   (grant),
        .timeout_o (tout)
    );

    // ------------------------------------------------------------------
    // Behavioural model: who owns the bus, who went last, BUSY age
    // ------------------------------------------------------------------
    bit            md_busy;
    int            md_owner;
    int            md_last;
    int            md_cnt;
    logic [1:0]    got_ack;

    logic [1:0]    e_grant;
    logic          e_scyc, e_sstb, e_swe, e_to;
    logic [SW-1:0] e_ssel;
    logic [AW-1:0] e_sadr;
    logic [DW-1:0] e_sdat;
    logic [1:0]    e_ack;
    logic [DW-1:0] e_dat [2];

    task automatic model_reset();
        md_busy  = 1'b0;
        md_owner = 0;
        md_last  = 1;
        md_cnt   = 0;
        got_ack  = 2'b00;
    endtask

    task automatic model_eval();
        int  o;
        bit  oc;
        e_grant = 2'b00; e_scyc = 1'b0; e_sstb = 1'b0; e_swe = 1'b0;
        e_ssel = '0; e_sadr = '0; e_sdat = '0; e_ack = 2'b00;
        e_dat[0] = '0; e_dat[1] = '0; e_to = 1'b0;
        if (!rst && md_busy) begin
            o        = md_owner;
            oc       = m_cyc[o];
            e_to     = TO_EN && oc && !s_ack && (md_cnt == TO_CYC - 1);
            e_scyc   = oc && !e_to;
            e_sstb   = m_stb[o] && !e_to;
            e_swe    = m_we[o];
            e_ssel   = m_sel[o];
            e_sadr   = m_adr[o];
            e_sdat   = m_dat[o];
            e_grant  = (o == 1) ? 2'b10 : 2'b01;
            e_ack[o] = oc && (s_ack || e_to);
            e_dat[o] = e_to ? TO_DAT : s_rdat;
        end
    endtask

    task automatic model_advance();
        bit r0, r1;
        model_eval();
        got_ack = e_ack;
        if (rst) begin
            model_reset();
        end else if (!md_busy) begin
            r0 = m_cyc[0] && m_stb[0];
            r1 = m_cyc[1] && m_stb[1];
            if (r0 || r1) begin
                md_owner = (r0 && r1) ? (1 - md_last) : (r0 ? 0 : 1);
                md_busy  = 1'b1;
                md_cnt   = 0;
            end
        end else if (!m_cyc[md_owner] || s_ack || e_to) begin
            md_busy = 1'b0;
            md_last = md_owner;
        end else begin
            md_cnt++;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ph);
        #1;
        model_eval();
        check_val({ph, ":grant"},  grant,                 e_grant);
        check_val({ph, ":s_ctl"},  {s_cyc, s_stb, s_we},  {e_scyc, e_sstb, e_swe});
        check_val({ph, ":s_sel"},  s_sel,                 e_ssel);
        check_val({ph, ":s_adr"},  s_adr,                 e_sadr);
        check_val({ph, ":s_dat"},  s_wdat,                e_sdat);
        check_val({ph, ":acks"},   {m1_ack, m0_ack},      e_ack);
        check_val({ph, ":m0_dat"}, m0_rdat,               e_dat[0]);
        check_val({ph, ":m1_dat"}, m1_rdat,               e_dat[1]);
        check_val({ph, ":tmo"},    tout,                  e_to);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_advance();
    endtask

    task automatic new_req(input int n);
        m_cyc[n] = 1'b1;
        m_stb[n] = 1'b1;
        m_we[n]  = 1'($urandom_range(1, 0));
        m_sel[n] = SW'($urandom());
        m_adr[n] = $urandom();
        m_dat[n] = $urandom();
    endtask

    task automatic drop(input int n);
        m_cyc[n] = 1'b0;
        m_stb[n] = 1'b0;
    endtask

    task automatic idle_inputs();
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        for (int n = 0; n < 2; n++) begin
            m_sel[n] = '0; m_adr[n] = '0; m_dat[n] = '0;
        end
        s_ack  = 1'b0;
        s_rdat = '0;
    endtask

    // Start a single M0 request with fixed attributes
    task automatic m0_start();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_sel[0] = 4'hF; m_adr[0] = 32'h3000_0004; m_dat[0] = 32'h0000_1234;
    endtask

    // Bench time limit
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish within limit");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        // ---- M0 single write ----
        m0_start();
        check_all("t2_req");
        check_val("t2_stb_before_grant", s_stb, 1'b0);
        tick();
        check_all("t2_busy");
        check_val("t2_stb", s_stb, 1'b1);
        check_val("t2_adr", s_adr, 32'h3000_0004);
        check_val("t2_dat", s_wdat, 32'h0000_1234);
        check_val("t2_sel", s_sel, 4'hF);
        check_val("t2_grant", grant, 2'b01);
        s_ack = 1'b1;
        check_all("t2_ack");
        check_val("t2_m0_ack", m0_ack, 1'b1);
        tick();
        drop(0); s_ack = 1'b0;
        check_all("t2_done");
        check_val("t2_grant_idle", grant, 2'b00);

        // ---- M1 read ----
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_sel[1] = 4'hF; m_adr[1] = 32'h3000_0010; m_dat[1] = '0;
        tick();
        s_ack = 1'b1; s_rdat = 32'hA5A5_A5A5;
        check_all("t4_ack");
        check_val("t4_m1_dat", m1_rdat, 32'hA5A5_A5A5);
        check_val("t4_m1_ack", m1_ack, 1'b1);
        check_val("t4_m0_dat", m0_rdat, 32'h0);
        tick();
        drop(1); s_ack = 1'b0;
        check_all("t4_done");

        // ---- Both masters continuously, slave acks every cycle ----
        m0_start();
        new_req(1);
        s_ack = 1'b1;
        check_all("t3_start");
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_all("t3_loop");
            check_val("t3_grant_seq", grant,
                      (k % 2 == 0) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b01 : 2'b10));
        end
        drop(0); drop(1); s_ack = 1'b0;
        tick();
        check_all("t3_done");

        // ---- M0 abort with M1 pending ----
        m0_start();
        new_req(1);
        check_all("t5_req");
        tick();
        check_all("t5_busy");
        check_val("t5_grant_m0", grant, 2'b01);
        drop(0);
        check_all("t5_abort");
        check_val("t5_scyc", s_cyc, 1'b0);
        check_val("t5_m0_ack", m0_ack, 1'b0);
        tick();
        check_all("t5_dead");
        check_val("t5_grant_dead", grant, 2'b00);
        tick();
        check_all("t5_m1");
        check_val("t5_grant_m1", grant, 2'b10);
        s_ack = 1'b1;
        check_all("t5_m1_ack");
        tick();
        drop(1); s_ack = 1'b0;
        check_all("t5_done");

        // ---- Asynchronous reset mid-transaction ----
        m0_start();
        tick();
        s_ack = 1'b1;
        check_all("t1_busy");
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_val("t1_rst_scyc", s_cyc, 1'b0);
        check_val("t1_rst_grant", grant, 2'b00);
        check_val("t1_rst_ack", m0_ack, 1'b0);
        check_all("t1_rst");
        s_ack = 1'b0;
        new_req(1);
        @(posedge clk);
        #3 rst = 1'b0;
        check_all("t1_release");
        tick();
        check_all("t1_tie");
        check_val("t1_first_tie_m0", grant, 2'b01);
        s_ack = 1'b1;
        check_all("t1_ack");
        tick();
        drop(0); drop(1); s_ack = 1'b0;
        check_all("t1_done");

        // ---- Slave never acks ----
        m0_start();
        tick();
        for (int c = 1; c < TO_CYC; c++) begin
            check_all("t6_wait");
            tick();
        end
        check_all("t6_cyc16");
`ifdef USER_WB_ARB_TIMEOUT_EN
        check_val("t6_tmo", tout, 1'b1);
        check_val("t6_ack", m0_ack, 1'b1);
        check_val("t6_dat", m0_rdat, 32'hDEADBEEF);
        check_val("t6_scyc", s_cyc, 1'b0);
        tick();
        drop(0);
        check_all("t6_after");
`else
        check_val("t6_no_tmo", tout, 1'b0);
        check_val("t6_no_ack", m0_ack, 1'b0);
        for (int c = 0; c < 300; c++) begin
            tick();
            check_all("t6_hold");
        end
        check_val("t6_still_granted", grant, 2'b01);
        s_ack = 1'b1;
        check_all("t6_late_ack");
        tick();
        drop(0); s_ack = 1'b0;
        check_all("t6_after");
`endif

        // ---- Ack exactly on the last allowed cycle ----
        m0_start();
        tick();
        for (int c = 1; c < TO_CYC; c++) begin
            check_all("t6v_wait");
            tick();
        end
        s_ack = 1'b1; s_rdat = 32'h1122_3344;
        check_all("t6v_cyc16");
        check_val("t6v_no_tmo", tout, 1'b0);
        check_val("t6v_ack", m0_ack, 1'b1);
        check_val("t6v_dat", m0_rdat, 32'h1122_3344);
        tick();
        drop(0); s_ack = 1'b0;
        check_all("t6v_done");

        // ---- Randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                if (m_cyc[n]) begin
                    if (got_ack[n]) begin
                        if ($urandom_range(1, 0) == 1) new_req(n);
                        else drop(n);
                    end else if ($urandom_range(29, 0) == 0) begin
                        drop(n);
                    end else begin
                        m_stb[n] = ($urandom_range(9, 0) != 0);
                    end
                end else if ($urandom_range(9, 0) < 4) begin
                    new_req(n);
                end
            end
            s_ack  = ($urandom_range(9, 0) < 4);
            s_rdat = $urandom();
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
